// File: rtl/ad9258_spi_target.sv
// ad9258_spi_target
// -----------------------------------------------------------------------------
// 3-wire SPI responder that emulates the AD9258 configuration port. Frames are
// 24 bits, MSB first: R/W, W1:W0, 13-bit address, 8-bit data. Every frame
// moves exactly one byte; W1:W0 is captured but has no effect. Frames are
// backed by a local byte-wide register file.
//
// Parameters:
//   DEPTH       - number of implemented byte registers (addresses 0..DEPTH-1)
//   CHIP_ID     - value returned by read-only address 0x001
//   SYNC_STAGES - synchronizer depth on sclk, csb and sdio_in
//
// Ports:
//   clk, rst          - system clock (>= 6x sclk); synchronous active-high reset
//   sclk, csb         - serial clock and active-low chip select (asynchronous)
//   sdio_in           - sdio pad input
//   sdio_out, sdio_oe - sdio pad output value and output enable (1 = drive)
//   loc_addr          - local read address
//   loc_rdata         - register contents at loc_addr, one cycle later
//   wr_stb            - one-cycle pulse when a serial write commits
//   wr_addr, wr_data  - address/data of the last committed write
//   busy              - a frame is in progress (state is not IDLE)
//
// Build option: define AD9258_TGT_SHADOW_EN to route serial writes into a
// shadow array. Writing 0x01 to 0x0FF copies shadow to active in one cycle and
// the bit then self-clears; 0x0FF reads 0x01 only during that copy cycle.
// Without the macro, writes land in the active array and 0x0FF is ordinary.
//
// The FSM has no valid/ready handshake; the serial side is paced entirely by
// sclk edges and csb, and wr_stb is a fire-and-forget notification.
module ad9258_spi_target #(
  parameter int         DEPTH       = 256,
  parameter logic [7:0] CHIP_ID     = 8'h32,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        csb,
  input  logic        sdio_in,
  output logic        sdio_out,
  output logic        sdio_oe,
  input  logic [12:0] loc_addr,
  output logic [7:0]  loc_rdata,
  output logic        wr_stb,
  output logic [12:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [13:0] DEPTH_L = 14'(DEPTH);

  typedef enum logic [2:0] {IDLE, HDR, RDATA, WDATA, DONE} state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sclk_q, csb_q, sdi_q;
  logic        sclk_s, csb_s, sdi_s, sclk_d, rise;
  logic [14:0] hdr;
  logic [15:0] hdr_w;
  logic [1:0]  wlen_unused;
  logic [4:0]  bit_cnt;
  logic [12:0] addr_q;
  logic [7:0]  dat_q;
  logic [7:0]  rd_sh;
  logic [7:0]  ser_rval;
  logic        commit_q;
  logic        wr_ok;
  logic [7:0]  regs [DEPTH];
`ifdef AD9258_TGT_SHADOW_EN
  logic [7:0]  sh_regs [DEPTH];
  logic        xfer_q;
`endif

  // Reset csb to the deselected level so no phantom frame starts afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= '0;
      csb_q  <= '1;
      sdi_q  <= '0;
    end else begin
      sclk_q[0] <= sclk;
      csb_q[0]  <= csb;
      sdi_q[0]  <= sdio_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_q[i] <= sclk_q[i-1];
        csb_q[i]  <= csb_q[i-1];
        sdi_q[i]  <= sdi_q[i-1];
      end
    end
  end

  assign sclk_s      = sclk_q[SYNC_STAGES-1];
  assign csb_s       = csb_q[SYNC_STAGES-1];
  assign sdi_s       = sdi_q[SYNC_STAGES-1];
  assign rise        = sclk_s & ~sclk_d;
  assign hdr_w       = {hdr, sdi_s};
  assign wlen_unused = hdr_w[14:13];
  assign busy        = (state != IDLE);

  // Shared read decode for the serial and local ports.
  function automatic logic [7:0] rd_sel(input logic [12:0] a);
    logic [7:0] v;
    v = 8'h00;
    if (a == 13'h001) begin
      v = CHIP_ID;
`ifdef AD9258_TGT_SHADOW_EN
    end else if (a == 13'h0FF) begin
      v = {7'b0, xfer_q};
`endif
    end else if ({1'b0, a} < DEPTH_L) begin
      v = regs[a[AW-1:0]];
    end
    return v;
  endfunction

  always_comb ser_rval = rd_sel(hdr_w[12:0]);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (!csb_s) state_n = HDR;
      HDR: begin
        if (csb_s)                            state_n = IDLE;
        else if (rise && bit_cnt == 5'd15)    state_n = hdr_w[15] ? RDATA : WDATA;
      end
      RDATA, WDATA: begin
        if (csb_s)                            state_n = IDLE;
        else if (rise && bit_cnt == 5'd23)    state_n = DONE;
      end
      DONE:  if (csb_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Serial datapath: header/data shifting and read-data output.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_d   <= 1'b0;
      hdr      <= '0;
      bit_cnt  <= '0;
      addr_q   <= '0;
      dat_q    <= '0;
      rd_sh    <= '0;
      sdio_out <= 1'b0;
      sdio_oe  <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      sclk_d   <= sclk_s;
      commit_q <= 1'b0;
      case (state)
        IDLE: bit_cnt <= '0;
        HDR: if (!csb_s && rise) begin
          hdr     <= hdr_w[14:0];
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd15) begin
            addr_q <= hdr_w[12:0];
            if (hdr_w[15]) begin
              rd_sh    <= ser_rval;
              sdio_out <= ser_rval[7];
              sdio_oe  <= 1'b1;
            end
          end
        end
        RDATA: if (!csb_s && rise) begin
          bit_cnt <= bit_cnt + 5'd1;
          // The 24th edge only closes the frame; bit 0 stays on the pad.
          if (bit_cnt != 5'd23) begin
            rd_sh    <= {rd_sh[6:0], 1'b0};
            sdio_out <= rd_sh[6];
          end
        end
        WDATA: if (!csb_s && rise) begin
          bit_cnt <= bit_cnt + 5'd1;
          dat_q   <= {dat_q[6:0], sdi_s};
          if (bit_cnt == 5'd23) commit_q <= 1'b1;
        end
        default: ;
      endcase
      if (csb_s) begin
        sdio_oe  <= 1'b0;
        sdio_out <= 1'b0;
      end
    end
  end

`ifdef AD9258_TGT_SHADOW_EN
  assign wr_ok = (addr_q == 13'h0FF) ||
                 ((addr_q != 13'h001) && ({1'b0, addr_q} < DEPTH_L));
`else
  assign wr_ok = (addr_q != 13'h001) && ({1'b0, addr_q} < DEPTH_L);
`endif

  // Register file, commit strobe and local read port. The local read samples
  // the array before this cycle's commit lands, so it returns the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
`ifdef AD9258_TGT_SHADOW_EN
      for (int i = 0; i < DEPTH; i++) sh_regs[i] <= '0;
      xfer_q <= 1'b0;
`endif
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      loc_rdata <= '0;
    end else begin
      wr_stb    <= 1'b0;
      loc_rdata <= rd_sel(loc_addr);
`ifdef AD9258_TGT_SHADOW_EN
      xfer_q <= 1'b0;
      if (xfer_q) regs <= sh_regs;
`endif
      if (commit_q && wr_ok) begin
        wr_stb  <= 1'b1;
        wr_addr <= addr_q;
        wr_data <= dat_q;
`ifdef AD9258_TGT_SHADOW_EN
        if (addr_q == 13'h0FF) xfer_q <= dat_q[0];
        else                   sh_regs[addr_q[AW-1:0]] <= dat_q;
`else
        regs[addr_q[AW-1:0]] <= dat_q;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ad9258_spi_target.sv
// tb_ad9258_spi_target
// Directed bench for ad9258_spi_target: an sclk = clk/8 initiator drives
// 24-bit frames, samples sdio_out on sclk falling edges, and every result is
// compared against hand-computed constants.
module tb_ad9258_spi_target;

  logic        clk = 1'b0;
  logic        rst, sclk, csb, sdio_in;
  logic        sdio_out, sdio_oe;
  logic [12:0] loc_addr;
  logic [7:0]  loc_rdata;
  logic        wr_stb;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int stb_cnt = 0;
  logic [7:0] loc_at_stb = '0;
  logic [7:0] loc_after_stb = '0;
  logic       grab_next = 1'b0;

  // ---------------- clock / reset
  always #5 clk = ~clk;

  ad9258_spi_target dut (
    .clk(clk), .rst(rst), .sclk(sclk), .csb(csb), .sdio_in(sdio_in),
    .sdio_out(sdio_out), .sdio_oe(sdio_oe), .loc_addr(loc_addr),
    .loc_rdata(loc_rdata), .wr_stb(wr_stb), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy)
  );

  // ---------------- scoreboard helpers
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Counts commit pulses and records the local read port around each pulse.
  always @(negedge clk) begin
    if (grab_next) begin
      loc_after_stb = loc_rdata;
      grab_next = 1'b0;
    end
    if (wr_stb) begin
      stb_cnt++;
      loc_at_stb = loc_rdata;
      grab_next = 1'b1;
    end
  end

  // ---------------- driver tasks
  // nbits < 24 aborts the frame early; rst_bit >= 0 asserts rst after that
  // bit's rising edge and abandons the frame.
  task automatic spi_xfer(input logic [23:0] frm, input int nbits, input int rst_bit,
                          output logic [7:0] rd);
    logic is_rd;
    is_rd = frm[23];
    rd = '0;
    csb = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sdio_in = frm[23-i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      if (i == 0) check("busy_mid", busy, 1);
      if (i == rst_bit) begin
        check("oe_before_rst", sdio_oe, 1);
        rst = 1'b1; csb = 1'b1; sclk = 1'b0;
        @(negedge clk);
        check("oe_after_rst", sdio_oe, 0);
        check("busy_after_rst", busy, 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        return;
      end
      if (is_rd && i >= 15 && i <= 22) begin
        check("oe_during_read", sdio_oe, 1);
        rd = {rd[6:0], sdio_out};
      end
      sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
    if (nbits == 24) begin
      if (is_rd) check("oe_hold", sdio_oe, 1);
      else       check("oe_write", sdio_oe, 0);
    end
    csb = 1'b1;
    repeat (6) @(negedge clk);
    check("oe_idle", sdio_oe, 0);
    check("busy_idle", busy, 0);
  endtask

  task automatic spi_write(input logic [12:0] a, input logic [7:0] d);
    logic [7:0] dummy;
    spi_xfer({1'b0, 2'b00, a, d}, 24, -1, dummy);
  endtask

  task automatic spi_read(input logic [12:0] a, output logic [7:0] v);
    spi_xfer({1'b1, 2'b00, a, 8'h00}, 24, -1, v);
  endtask

  task automatic loc_read(input logic [12:0] a, output logic [7:0] v);
    @(negedge clk);
    loc_addr = a;
    @(negedge clk);
    v = loc_rdata;
  endtask

  // ---------------- stimulus
  initial begin
    int s0;
    logic [7:0] v;
    rst = 1'b1; sclk = 1'b0; csb = 1'b1; sdio_in = 1'b0; loc_addr = '0;
    repeat (4) @(negedge clk);
    check("rst_sdio_out", sdio_out, 0);
    check("rst_sdio_oe", sdio_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_stb", wr_stb, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_loc_rdata", loc_rdata, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // basic write 0x000814
    s0 = stb_cnt;
    spi_xfer(24'h000814, 24, -1, v);
    check("w1_stb_count", stb_cnt - s0, 1);
    check("w1_wr_addr", wr_addr, 13'h008);
    check("w1_wr_data", wr_data, 8'h14);
    loc_read(13'h008, v);
    check("w1_loc", v, 8'h14);

    // chip id read
    s0 = stb_cnt;
    spi_xfer(24'h800100, 24, -1, v);
    check("chip_id_serial", v, 8'h32);
    check("rd_no_stb", stb_cnt - s0, 0);
    loc_read(13'h001, v);
    check("chip_id_loc", v, 8'h32);

    // out-of-range write, no aliasing onto 0x000
    s0 = stb_cnt;
    spi_write(13'h0200, 8'hA5);
    check("oor_no_stb", stb_cnt - s0, 0);
    check("oor_wr_addr_kept", wr_addr, 13'h008);
    spi_read(13'h0200, v);
    check("oor_read", v, 8'h00);
    spi_read(13'h0000, v);
    check("no_alias_0", v, 8'h00);

    // chip id is read-only
    s0 = stb_cnt;
    spi_write(13'h0001, 8'hAB);
    check("ro_no_stb", stb_cnt - s0, 0);
    spi_read(13'h0001, v);
    check("ro_still_id", v, 8'h32);

`ifndef AD9258_TGT_SHADOW_EN
    // last implemented register is ordinary storage
    s0 = stb_cnt;
    spi_write(13'h00FF, 8'h3E);
    check("top_stb", stb_cnt - s0, 1);
    spi_read(13'h00FF, v);
    check("top_read", v, 8'h3E);
`endif

    // abort after 20 bits of a write to 0x010
    s0 = stb_cnt;
    spi_xfer(24'h001077, 20, -1, v);
    check("abort_no_stb", stb_cnt - s0, 0);
    loc_read(13'h010, v);
    check("abort_reg", v, 8'h00);
    s0 = stb_cnt;
    spi_write(13'h010, 8'h77);
    check("after_abort_stb", stb_cnt - s0, 1);
    loc_read(13'h010, v);
    check("after_abort_reg", v, 8'h77);

    // reset during bit 18 of a read
    spi_xfer(24'h800800, 24, 17, v);
    loc_read(13'h008, v);
    check("rst_clr_008", v, 8'h00);
    loc_read(13'h010, v);
    check("rst_clr_010", v, 8'h00);
    check("rst_clr_wr_addr", wr_addr, 0);
    check("rst_clr_wr_data", wr_data, 0);

    // recovery write; local read of the same address sees old then new value
    @(negedge clk);
    loc_addr = 13'h005;
    s0 = stb_cnt;
    spi_write(13'h005, 8'h3C);
    check("rec_stb", stb_cnt - s0, 1);
    check("loc_old_at_commit", loc_at_stb, 8'h00);
    check("loc_new_after", loc_after_stb, 8'h3C);
    spi_read(13'h005, v);
    check("rec_read", v, 8'h3C);

`ifdef AD9258_TGT_SHADOW_EN
    s0 = stb_cnt;
    spi_write(13'h014, 8'h5A);
    check("sh_stb", stb_cnt - s0, 1);
    spi_read(13'h014, v);
    check("sh_not_active", v, 8'h00);
    s0 = stb_cnt;
    spi_write(13'h0FF, 8'h01);
    check("xfer_stb", stb_cnt - s0, 1);
    spi_read(13'h014, v);
    check("xfer_active", v, 8'h5A);
    spi_read(13'h0FF, v);
    check("xfer_selfclr", v, 8'h00);
    loc_read(13'h014, v);
    check("xfer_loc", v, 8'h5A);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
